// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN RAM loader: FSM state encoding,
// default widths and a small power-of-two helper for capacity checks.
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_IMG,
    LOAD_WGT,
    CONV
  } loader_state_e;

  localparam int DEF_DATA_W  = 128;
  localparam int DEF_KSIZE   = 5;
  localparam int DEF_IMG_AW  = 10;
  localparam int DEF_WGT_AW  = 5;
  localparam int DEF_DIM_W   = 6;
  localparam int DEF_CH_W    = 5;
  localparam int DEF_LAYER_W = 3;

  // Capacity of a RAM with the given address width, as a 32-bit count.
  function automatic logic [31:0] pow2(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/cnn_ram_loader_if.sv
// Valid/ready stream feeding the loader: the source is the master, the loader
// the slave.
interface cnn_ram_loader_if
  import cnn_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/cnn_edge_detect.sv
// Synchronous rising-edge detector: two-flop history of the input, pulse
// while the newest sample is 1 and the one before it is 0.
module cnn_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic cur;
  logic prev;

  // NOTE: non-blocking so cur and prev shift together like real flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur  <= 1'b0;
      prev <= 1'b0;
    end else begin
      cur  <= din;
      prev <= cur;
    end
  end

  assign rise = cur & ~prev;

endmodule

// File: rtl/cnn_ram_loader.sv
// Layer loader: fills image then weight RAM from a valid/ready stream, holds
// conv_start until the conv engine finishes. Macro LOADER_TEST_PATTERN_EN
// replaces stream data with a per-RAM incrementing counter at one word/cycle.
module cnn_ram_loader
  import cnn_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int IMG_AW  = DEF_IMG_AW,
  parameter int WGT_AW  = DEF_WGT_AW,
  parameter int KSIZE   = DEF_KSIZE,
  parameter int DIM_W   = DEF_DIM_W,
  parameter int CH_W    = DEF_CH_W,
  parameter int LAYER_W = DEF_LAYER_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_req,
  input  logic [DIM_W-1:0]   cfg_w,
  input  logic [DIM_W-1:0]   cfg_h,
  input  logic [CH_W-1:0]    cfg_c,
  cnn_ram_loader_if.slave    strm,
  input  logic               conv_finish,
  output logic               conv_start,
  output logic               busy,
  output logic               cfg_err,
  output logic [LAYER_W-1:0] cnn_state,
  output logic [DIM_W-1:0]   W,
  output logic [DIM_W-1:0]   H,
  output logic [CH_W-1:0]    C,
  output logic               ram_image_en,
  output logic               ram_image_we,
  output logic [IMG_AW-1:0]  ram_image_addr,
  output logic [DATA_W-1:0]  ram_image_din,
  output logic               ram_weight_en,
  output logic               ram_weight_we,
  output logic [WGT_AW-1:0]  ram_weight_addr,
  output logic [DATA_W-1:0]  ram_weight_din
);

  loader_state_e state;
  loader_state_e nextState;

  logic [31:0]       nImg;
  logic [31:0]       nWgt;
  logic              cfgOk;
  logic              loadAccept;
  logic              loadReject;
  logic [IMG_AW-1:0] imgAddr;
  logic [IMG_AW-1:0] imgLast;
  logic [WGT_AW-1:0] wgtAddr;
  logic [WGT_AW-1:0] wgtLast;
  logic              strmValid;
  logic [DATA_W-1:0] imgData;
  logic [DATA_W-1:0] wgtData;
  logic              sReady;
  logic              imgAccept;
  logic              wgtAccept;
  logic              finishRise;
  logic              convDone;
  logic              convStartNext;

  // Products are formed at 32 bits so an oversized layer cannot wrap into range.
  assign nImg  = 32'(cfg_w) * 32'(cfg_h) * 32'(cfg_c);
  assign nWgt  = 32'(KSIZE * KSIZE) * 32'(cfg_c);
  assign cfgOk = (cfg_w != '0) && (cfg_h != '0) && (cfg_c != '0) &&
                 (nImg <= pow2(IMG_AW)) && (nWgt <= pow2(WGT_AW));

`ifdef LOADER_TEST_PATTERN_EN
  // The fill address doubles as the pattern counter: it restarts at 0 per RAM.
  assign strmValid = 1'b1;
  assign imgData   = DATA_W'(imgAddr);
  assign wgtData   = DATA_W'(wgtAddr);
`else
  assign strmValid = strm.s_valid;
  assign imgData   = strm.s_data;
  assign wgtData   = strm.s_data;
`endif

  assign strm.s_ready = sReady;

  cnn_edge_detect uFinishEdge (
    .clk  (clk),
    .rst  (rst),
    .din  (conv_finish),
    .rise (finishRise)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:     if (loadAccept)                        nextState = LOAD_IMG;
      LOAD_IMG: if (imgAccept && (imgAddr == imgLast)) nextState = LOAD_WGT;
      LOAD_WGT: if (wgtAccept && (wgtAddr == wgtLast)) nextState = CONV;
      CONV:     if (convDone)                          nextState = IDLE;
      default:                                         nextState = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path leaves one unassigned.
  always_comb begin
    sReady        = 1'b0;
    busy          = 1'b0;
    imgAccept     = 1'b0;
    wgtAccept     = 1'b0;
    loadAccept    = 1'b0;
    loadReject    = 1'b0;
    convDone      = 1'b0;
    convStartNext = 1'b0;
    unique case (state)
      IDLE: begin
        loadAccept = load_req && cfgOk;
        loadReject = load_req && !cfgOk;
      end
      LOAD_IMG: begin
        busy      = 1'b1;
        sReady    = 1'b1;
        imgAccept = strmValid;
      end
      LOAD_WGT: begin
        busy      = 1'b1;
        sReady    = 1'b1;
        wgtAccept = strmValid;
      end
      CONV: begin
        busy          = 1'b1;
        // conv_start is only high from the second CONV cycle, so an edge that
        // was already in the history when CONV was entered cannot end the layer.
        convDone      = conv_start && finishRise;
        convStartNext = !convDone;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      conv_start      <= 1'b0;
      cfg_err         <= 1'b0;
      cnn_state       <= '0;
      W               <= '0;
      H               <= '0;
      C               <= '0;
      imgAddr         <= '0;
      imgLast         <= '0;
      wgtAddr         <= '0;
      wgtLast         <= '0;
      ram_image_en    <= 1'b0;
      ram_image_we    <= 1'b0;
      ram_image_addr  <= '0;
      ram_image_din   <= '0;
      ram_weight_en   <= 1'b0;
      ram_weight_we   <= 1'b0;
      ram_weight_addr <= '0;
      ram_weight_din  <= '0;
    end else begin
      conv_start    <= convStartNext;
      ram_image_en  <= imgAccept;
      ram_image_we  <= imgAccept;
      ram_weight_en <= wgtAccept;
      ram_weight_we <= wgtAccept;

      if (loadAccept) begin
        W       <= cfg_w;
        H       <= cfg_h;
        C       <= cfg_c;
        imgLast <= IMG_AW'(nImg - 32'd1);
        wgtLast <= WGT_AW'(nWgt - 32'd1);
        imgAddr <= '0;
        wgtAddr <= '0;
        cfg_err <= 1'b0;
      end else if (loadReject) begin
        cfg_err <= 1'b1;
      end

      if (imgAccept) begin
        ram_image_addr <= imgAddr;
        ram_image_din  <= imgData;
        imgAddr        <= imgAddr + IMG_AW'(1);
      end

      if (wgtAccept) begin
        ram_weight_addr <= wgtAddr;
        ram_weight_din  <= wgtData;
        wgtAddr         <= wgtAddr + WGT_AW'(1);
      end

      if (convDone) cnn_state <= cnn_state + LAYER_W'(1);
    end
  end

endmodule
